// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file write arbiter and the datapath.
// Requester indices, default counter width and the write-port record.
package regfile_arb_pkg;

  localparam int REQ_DP    = 0;
  localparam int REQ_IO    = 1;
  localparam int CNT_W_DEF = 8;

  typedef struct packed {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
  } wr_t;

endpackage

// File: rtl/flopr.sv
// Plain register with synchronous active-high reset to zero.
// Latency 1 cycle; no backpressure, loads every clock.
module flopr #(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/sat_cnt.sv
// Saturating up-counter, synchronous active-high reset.
// Latency 1 cycle; holds at all-ones instead of wrapping.
module sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)                          q <= '0;
    else if (inc && (q != {WIDTH{1'b1}})) q <= q + 1'b1;
  end

endmodule

// File: rtl/regfile_arb.sv
// Two-requester write arbiter for the register-file write port; grants are
// combinational, the write port is registered (latency 1, one write per clock).
// Tie-break: round-robin when REGFILE_ARB_RR_EN is defined, else requester 0 wins.
module regfile_arb
  import regfile_arb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v0,
  input  logic [3:0]       wa0,
  input  logic [7:0]       wd0,
  input  logic             v1,
  input  logic [3:0]       wa1,
  input  logic [7:0]       wd1,
  output logic             g0,
  output logic             g1,
  output logic             we3,
  output logic [3:0]       wa3,
  output logic [7:0]       wd3,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [1:0] gnt;
  wr_t        wr_d;
  wr_t        wr_q;

`ifdef REGFILE_ARB_RR_EN
  // ptr names the requester preferred on a tie; it flips to the other side after any grant.
  logic ptr;

  always_ff @(posedge clk) begin
    if (reset)            ptr <= 1'b0;
    else if (gnt[REQ_DP]) ptr <= 1'b1;
    else if (gnt[REQ_IO]) ptr <= 1'b0;
  end

  always_comb begin
    gnt         = 2'b00;
    gnt[REQ_DP] = !reset && v0 && (!v1 || !ptr);
    gnt[REQ_IO] = !reset && v1 && (!v0 || ptr);
  end
`else
  always_comb begin
    gnt         = 2'b00;
    gnt[REQ_DP] = !reset && v0;
    gnt[REQ_IO] = !reset && v1 && !v0;
  end
`endif

  assign g0 = gnt[REQ_DP];
  assign g1 = gnt[REQ_IO];

  // Register 0 is hard-wired to zero, so a write to it is granted but not enabled.
  always_comb begin
    wr_d    = wr_q;
    wr_d.we = 1'b0;
    if (gnt[REQ_DP]) begin
      wr_d.we = (wa0 != 4'd0);
      wr_d.wa = wa0;
      wr_d.wd = wd0;
    end else if (gnt[REQ_IO]) begin
      wr_d.we = (wa1 != 4'd0);
      wr_d.wa = wa1;
      wr_d.wd = wd1;
    end
  end

  flopr #(.WIDTH(13)) u_wr_reg (
    .clk   (clk),
    .reset (reset),
    .d     (wr_d),
    .q     (wr_q)
  );

  assign we3 = wr_q.we;
  assign wa3 = wr_q.wa;
  assign wd3 = wr_q.wd;

  sat_cnt #(.WIDTH(CNT_W)) u_cnt0 (
    .clk   (clk),
    .reset (reset),
    .inc   (gnt[REQ_DP]),
    .q     (cnt0)
  );

  sat_cnt #(.WIDTH(CNT_W)) u_cnt1 (
    .clk   (clk),
    .reset (reset),
    .inc   (gnt[REQ_IO]),
    .q     (cnt1)
  );

endmodule

// File: tb/tb_regfile_arb.sv
// Directed bench for regfile_arb: a vector table on the default-width instance
// plus a hand sequence on a CNT_W=2 instance for counter saturation.
module tb_regfile_arb;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       v0, v1;
  logic [3:0] wa0, wa1;
  logic [7:0] wd0, wd1;
  logic       g0, g1, we3;
  logic [3:0] wa3;
  logic [7:0] wd3;
  logic [7:0] cnt0, cnt1;

  logic       s_reset;
  logic       s_v0;
  logic [3:0] s_wa0;
  logic [7:0] s_wd0;
  logic       s_g0, s_g1, s_we3;
  logic [3:0] s_wa3;
  logic [7:0] s_wd3;
  logic [1:0] s_cnt0, s_cnt1;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_arb #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .v0(v0), .wa0(wa0), .wd0(wd0),
    .v1(v1), .wa1(wa1), .wd1(wd1),
    .g0(g0), .g1(g1),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  regfile_arb #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(s_reset),
    .v0(s_v0), .wa0(s_wa0), .wd0(s_wd0),
    .v1(1'b0), .wa1(4'd0), .wd1(8'd0),
    .g0(s_g0), .g1(s_g1),
    .we3(s_we3), .wa3(s_wa3), .wd3(s_wd3),
    .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  typedef struct {
    logic       rst;
    logic       v0;
    logic [3:0] wa0;
    logic [7:0] wd0;
    logic       v1;
    logic [3:0] wa1;
    logic [7:0] wd1;
    logic       g0;
    logic       g1;
    logic       we3;
    logic [3:0] wa3;
    logic [7:0] wd3;
    logic [7:0] c0;
    logic [7:0] c1;
    logic       chk_dat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst,
                              input logic v0_, input logic [3:0] wa0_, input logic [7:0] wd0_,
                              input logic v1_, input logic [3:0] wa1_, input logic [7:0] wd1_,
                              input logic eg0, input logic eg1, input logic ewe,
                              input logic [3:0] ewa, input logic [7:0] ewd,
                              input logic [7:0] ec0, input logic [7:0] ec1,
                              input logic chk);
    vec_t v;
    v.rst = rst; v.v0 = v0_; v.wa0 = wa0_; v.wd0 = wd0_;
    v.v1 = v1_; v.wa1 = wa1_; v.wd1 = wd1_;
    v.g0 = eg0; v.g1 = eg1; v.we3 = ewe; v.wa3 = ewa; v.wd3 = ewd;
    v.c0 = ec0; v.c1 = ec1; v.chk_dat = chk;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0;
    wa0 = '0; wd0 = '0; wa1 = '0; wd1 = '0;
    s_reset = 1'b1; s_v0 = 1'b0; s_wa0 = '0; s_wd0 = '0;

    //            rst v0 wa0  wd0   v1 wa1  wd1    g0 g1 we wa3  wd3    c0 c1 chk
    vecs.push_back(mk(1, 1, 4'd5, 8'h55, 1, 4'd6, 8'h66, 0, 0, 0, 4'd0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4'd3, 8'h5A, 0, 4'd0, 8'h00, 1, 0, 1, 4'd3, 8'h5A, 1, 0, 1));
    vecs.push_back(mk(0, 0, 4'd0, 8'h00, 0, 4'd0, 8'h00, 0, 0, 0, 4'd3, 8'h5A, 1, 0, 1));
    vecs.push_back(mk(0, 0, 4'd0, 8'h00, 1, 4'd0, 8'hFF, 0, 1, 0, 4'd0, 8'h00, 1, 1, 0));
    vecs.push_back(mk(0, 0, 4'd0, 8'h00, 1, 4'd9, 8'hC3, 0, 1, 1, 4'd9, 8'hC3, 1, 2, 1));
`ifdef REGFILE_ARB_RR_EN
    vecs.push_back(mk(0, 1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 1, 0, 1, 4'd1, 8'h11, 2, 2, 1));
    vecs.push_back(mk(0, 1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 0, 1, 1, 4'd2, 8'h22, 2, 3, 1));
    vecs.push_back(mk(0, 1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 1, 0, 1, 4'd1, 8'h11, 3, 3, 1));
    vecs.push_back(mk(0, 1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 0, 1, 1, 4'd2, 8'h22, 3, 4, 1));
    vecs.push_back(mk(0, 1, 4'd7, 8'h77, 0, 4'd0, 8'h00, 1, 0, 1, 4'd7, 8'h77, 4, 4, 1));
`else
    vecs.push_back(mk(0, 1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 1, 0, 1, 4'd1, 8'h11, 2, 2, 1));
    vecs.push_back(mk(0, 1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 1, 0, 1, 4'd1, 8'h11, 3, 2, 1));
    vecs.push_back(mk(0, 1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 1, 0, 1, 4'd1, 8'h11, 4, 2, 1));
    vecs.push_back(mk(0, 1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 1, 0, 1, 4'd1, 8'h11, 5, 2, 1));
    vecs.push_back(mk(0, 1, 4'd7, 8'h77, 0, 4'd0, 8'h00, 1, 0, 1, 4'd7, 8'h77, 6, 2, 1));
`endif
    // Reset right after accepting the wa0=7 write: the write must be dropped.
    vecs.push_back(mk(1, 0, 4'd0, 8'h00, 1, 4'd4, 8'h44, 0, 0, 0, 4'd0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 1, 0, 1, 4'd1, 8'h11, 1, 0, 1));
`ifdef REGFILE_ARB_RR_EN
    vecs.push_back(mk(0, 1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 0, 1, 1, 4'd2, 8'h22, 1, 1, 1));
`else
    vecs.push_back(mk(0, 1, 4'd1, 8'h11, 1, 4'd2, 8'h22, 1, 0, 1, 4'd1, 8'h11, 2, 0, 1));
`endif

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      v0 = vecs[i].v0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      v1 = vecs[i].v1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      @(negedge clk);
      chk($sformatf("row%0d g0", i), {31'd0, g0}, {31'd0, vecs[i].g0});
      chk($sformatf("row%0d g1", i), {31'd0, g1}, {31'd0, vecs[i].g1});
      @(posedge clk); #1;
      chk($sformatf("row%0d we3", i), {31'd0, we3}, {31'd0, vecs[i].we3});
      if (vecs[i].chk_dat) begin
        chk($sformatf("row%0d wa3", i), {28'd0, wa3}, {28'd0, vecs[i].wa3});
        chk($sformatf("row%0d wd3", i), {24'd0, wd3}, {24'd0, vecs[i].wd3});
      end
      chk($sformatf("row%0d cnt0", i), {24'd0, cnt0}, {24'd0, vecs[i].c0});
      chk($sformatf("row%0d cnt1", i), {24'd0, cnt1}, {24'd0, vecs[i].c1});
    end
    v0 = 1'b0; v1 = 1'b0;

    // CNT_W=2: five back-to-back grants saturate cnt0 at 3 with no write bubbles.
    begin
      logic [1:0] exp_c [5];
      exp_c[0] = 2'd1; exp_c[1] = 2'd2; exp_c[2] = 2'd3; exp_c[3] = 2'd3; exp_c[4] = 2'd3;
      @(posedge clk); #1;
      chk("small reset cnt0", {30'd0, s_cnt0}, 32'd0);
      chk("small reset we3", {31'd0, s_we3}, 32'd0);
      s_reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
        s_v0 = 1'b1; s_wa0 = 4'(k + 1); s_wd0 = 8'(8'hA0 + k);
        @(negedge clk);
        chk($sformatf("small%0d g0", k), {31'd0, s_g0}, 32'd1);
        @(posedge clk); #1;
        chk($sformatf("small%0d cnt0", k), {30'd0, s_cnt0}, {30'd0, exp_c[k]});
        chk($sformatf("small%0d we3", k), {31'd0, s_we3}, 32'd1);
        chk($sformatf("small%0d wa3", k), {28'd0, s_wa3}, 32'(k + 1));
        chk($sformatf("small%0d wd3", k), {24'd0, s_wd3}, 32'(8'hA0 + k));
      end
      s_v0 = 1'b0;
      @(posedge clk); #1;
      chk("small idle we3", {31'd0, s_we3}, 32'd0);
      chk("small idle cnt1", {30'd0, s_cnt1}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_arb.md
REGFILE_ARB -- requirements
Module: regfile_arb

Interface
REQ-001 Parameter CNT_W, default 8, width of each per-requester grant counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 v0  input  1  requester 0 (datapath writeback) write request valid.
REQ-005 wa0  input  4  requester 0 destination register address.
REQ-006 wd0  input  8  requester 0 write data.
REQ-007 v1  input  1  requester 1 (I/O input port) write request valid.
REQ-008 wa1  input  4  requester 1 destination register address.
REQ-009 wd1  input  8  requester 1 write data.
REQ-010 g0  output  1  grant to requester 0; combinational, same cycle as accepted v0.
REQ-011 g1  output  1  grant to requester 1; combinational, same cycle as accepted v1.
REQ-012 we3  output  1  registered write enable to register file.
REQ-013 wa3  output  4  registered write address to register file.
REQ-014 wd3  output  8  registered write data to register file.
REQ-015 cnt0, cnt1  output  CNT_W  saturating counts of grants issued to requester 0 and requester 1.

Function
REQ-016 At most one of g0/g1 SHALL be high in any cycle; a request is accepted only when its valid and grant are both high.
REQ-017 Requesters SHALL hold valid, address and data stable until granted; the arbiter SHALL never withdraw a pending request.
REQ-018 Only one valid asserted -> that requester SHALL be granted in the same cycle.
REQ-019 Both valid, tie-break per Configuration (REQ-029/030).
REQ-020 Accepted request in cycle N -> we3=1, wa3/wd3 = granted address/data in cycle N+1 (latency 1); no acceptance in cycle N -> we3=0 in N+1, wa3/wd3 hold previous values.
REQ-021 Accepted request with address 0 SHALL be granted and counted but SHALL produce we3=0 in N+1, because register 0 reads as zero.
REQ-022 Each grant increments its counter by 1; at 2^CNT_W-1 the counter SHALL saturate, never wrap.
REQ-023 Back-to-back acceptances SHALL produce consecutive write cycles with no bubble; throughput is one write per clock.

Reset
REQ-024 reset=1 at a rising edge SHALL force we3=0, wa3=0, wd3=0, cnt0=0, cnt1=0, and the round-robin pointer to requester 0.
REQ-025 While reset=1, g0 and g1 SHALL be 0 regardless of v0/v1.
REQ-026 Reset in the cycle after an acceptance SHALL suppress that pending write (we3=0 after the edge); the requester sees it as granted.
REQ-027 The first grant is permitted in the cycle in which reset is low.

Configuration
REQ-028 Macro REGFILE_ARB_RR_EN selects the tie-break policy.
REQ-029 REGFILE_ARB_RR_EN defined: a 1-bit pointer names the preferred requester; on a tie the preferred requester is granted, and after any grant the pointer moves to the other requester.
REQ-030 REGFILE_ARB_RR_EN undefined: fixed priority; requester 0 always wins a tie; no pointer state exists.

Structure
REQ-031 Requester index constants (REQ_DP=0, REQ_IO=1) and the default CNT_W SHALL live in the shared package/include used by the datapath.
REQ-032 The saturating counter SHALL be a sub-module sat_cnt (parameter width; ports clk, reset, inc, q), instantiated twice.
REQ-033 Output registers SHALL be built from the team's existing plain register component with WIDTH 13 ({we,wa,wd}).

Verification
REQ-034 Reset, then v0=1 wa0=3 wd0=0x5A alone -> g0=1 same cycle; next cycle we3=1 wa3=3 wd3=0x5A; cnt0=1.
REQ-035 RR_EN defined, v0=v1=1 held 4 cycles -> grants g0,g1,g0,g1; cnt0=2, cnt1=2; four consecutive we3=1 cycles.
REQ-036 RR_EN undefined, v0=v1=1 held 3 cycles -> g0 every cycle, g1=0; cnt1 stays 0.
REQ-037 v1=1 wa1=0 wd1=0xFF -> g1=1, cnt1 increments, next cycle we3=0.
REQ-038 CNT_W=2, 5 grants to requester 0 -> cnt0 reads 1,2,3,3,3.
REQ-039 Accept v0 wa0=7 in cycle N, reset=1 in cycle N+1 -> we3=0 after edge, all counters 0, pointer at requester 0.
